controller: RTL and testbench

Main decode unit of the five-stage pipelined MIPS datapath, placed at the end of the ID stage. It decodes the 32-bit instruction word into datapath control signals. The result is registered on the clock, so the control word enters the ID/EX boundary one cycle after the instruction is presented.

---
 rtl/controller.sv | 182 ++++++++++++++++++
 tb/tb_controller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/controller.sv
// Main decoder at the end of ID: turns the instruction word into the registered ID/EX control word.
// Latency: 1 cycle from Instruction to outputs; Reset clears outputs asynchronously, Flush loads a bubble.
// Backpressure: none; a new word is decoded every cycle, and stalls are handled by the pipeline around it.
// Optional feature: define CONTROLLER_MUL_EN to decode R-type funct 011000 as MUL.
module controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Flush,
    input  logic [31:0] Instruction,
    output logic        RegDst,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        Branch,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        Jump,
    output logic        JRMux,
    output logic        JalMux,
    output logic [1:0]  MemSize
);

    // ALU operation codes seen by the EX stage
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
`ifdef CONTROLLER_MUL_EN
    localparam logic [3:0] ALU_MUL  = 4'b1001;
`endif
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLTZ = 4'b1011;
    localparam logic [3:0] ALU_BGEZ = 4'b1100;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       jump;
        logic       jr_mux;
        logic       jal_mux;
        logic [1:0] mem_size;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;
    ctrl_t      dec;
    ctrl_t      ctrl_q;

    assign opcode = Instruction[31:26];
    assign rt     = Instruction[20:16];
    assign funct  = Instruction[5:0];

    // rs, rd, shamt and the immediate are consumed elsewhere in the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{Instruction[25:21], Instruction[15:6]};

    // Combinational decode; anything not recognised falls out as the all-zero bubble.
    always_comb begin
        dec = CTRL_ZERO;
        unique case (opcode)
            6'b000000: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    6'b100000: dec.alu_op = ALU_ADD;
                    6'b100010: dec.alu_op = ALU_SUB;
                    6'b100100: dec.alu_op = ALU_AND;
                    6'b100101: dec.alu_op = ALU_OR;
                    6'b100110: dec.alu_op = ALU_XOR;
                    6'b100111: dec.alu_op = ALU_NOR;
                    6'b101010: dec.alu_op = ALU_SLT;
                    6'b000000: dec.alu_op = ALU_SLL;   // also the all-zero NOP: writes $0
                    6'b000010: dec.alu_op = ALU_SRL;
`ifdef CONTROLLER_MUL_EN
                    6'b011000: dec.alu_op = ALU_MUL;
`endif
                    6'b001000: begin
                        dec           = CTRL_ZERO;
                        dec.jump      = 1'b1;
                        dec.jr_mux    = 1'b1;
                    end
                    default:   dec = CTRL_ZERO;
                endcase
            end
            6'b000100: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;               // taken when the difference is zero
            end
            6'b000101: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_BNE;
            end
            6'b000001: begin
                // REGIMM: the condition lives in the rt field
                if (rt == 5'b00000) begin
                    dec.branch = 1'b1;
                    dec.alu_op = ALU_BLTZ;
                end else if (rt == 5'b00001) begin
                    dec.branch = 1'b1;
                    dec.alu_op = ALU_BGEZ;
                end
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (opcode)
                    6'b001100: dec.alu_op = ALU_AND;
                    6'b001101: dec.alu_op = ALU_OR;
                    6'b001110: dec.alu_op = ALU_XOR;
                    6'b001010: dec.alu_op = ALU_SLT;
                    default:   dec.alu_op = ALU_ADD;
                endcase
            end
            6'b100011, 6'b100001, 6'b100000: begin
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_size   = (opcode == 6'b100001) ? SZ_HALF :
                                 (opcode == 6'b100000) ? SZ_BYTE : SZ_WORD;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
                dec.mem_size  = (opcode == 6'b101001) ? SZ_HALF :
                                (opcode == 6'b101000) ? SZ_BYTE : SZ_WORD;
            end
            6'b000010: dec.jump = 1'b1;
            6'b000011: begin
                dec.jump      = 1'b1;
                dec.jal_mux   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec = CTRL_ZERO;
        endcase
    end

    // Control word register: Reset wins, then Flush inserts a bubble, else take the decode.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            ctrl_q <= CTRL_ZERO;
        else if (Flush)
            ctrl_q <= CTRL_ZERO;
        else
            ctrl_q <= dec;
    end

    assign RegDst   = ctrl_q.reg_dst;
    assign ALUOp    = ctrl_q.alu_op;
    assign ALUSrc   = ctrl_q.alu_src;
    assign Branch   = ctrl_q.branch;
    assign RegWrite = ctrl_q.reg_write;
    assign MemWrite = ctrl_q.mem_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign Jump     = ctrl_q.jump;
    assign JRMux    = ctrl_q.jr_mux;
    assign JalMux   = ctrl_q.jal_mux;
    assign MemSize  = ctrl_q.mem_size;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: hand-computed control words checked one cycle after each instruction.
module tb_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Flush;
    logic [31:0] Instruction;
    logic        RegDst, ALUSrc, Branch, RegWrite, MemWrite, MemRead, MemToReg;
    logic        Jump, JRMux, JalMux;
    logic [3:0]  ALUOp;
    logic [1:0]  MemSize;

    int n_checks = 0;
    int n_fail   = 0;

    controller dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .Instruction(Instruction),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToReg(MemToReg), .Jump(Jump), .JRMux(JRMux), .JalMux(JalMux),
        .MemSize(MemSize)
    );

    always #5 Clk = ~Clk;

    // Observed control word, field order: RegDst ALUOp ALUSrc Branch RegWrite MemWrite MemRead MemToReg Jump JRMux JalMux MemSize
    logic [15:0] obs;
    assign obs = {RegDst, ALUOp, ALUSrc, Branch, RegWrite, MemWrite, MemRead,
                  MemToReg, Jump, JRMux, JalMux, MemSize};

    function automatic logic [15:0] cw(input logic rd, input logic [3:0] op, input logic src,
                                       input logic br, input logic rw, input logic mw,
                                       input logic mr, input logic m2r, input logic j,
                                       input logic jr, input logic jal, input logic [1:0] sz);
        return {rd, op, src, br, rw, mw, mr, m2r, j, jr, jal, sz};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Present instruction away from the edge, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] instr, input logic fl, input string tag,
                        input logic [15:0] exp);
        @(negedge Clk);
        Instruction = instr;
        Flush       = fl;
        @(posedge Clk);
        #1;
        check(tag, exp);
    endtask

    localparam logic [15:0] ZERO = 16'h0000;

    initial begin
        Reset = 1'b1; Flush = 1'b0; Instruction = 32'h0000_0020;
        #12;
        check("reset_initial", ZERO);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("add_after_reset", cw(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));

        // Mid-cycle asynchronous reset
        #2; Reset = 1'b1; #1;
        check("async_reset", ZERO);
        #1; Reset = 1'b0; #1;
        check("reset_release_holds", ZERO);
        @(posedge Clk); #1;
        check("add_after_release", cw(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));

        // R-type sweep
        step(32'h0000_0024, 0, "r_and", cw(1, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0022, 0, "r_sub", cw(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_002A, 0, "r_slt", cw(1, 4'b0110, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0000, 0, "r_sll_nop", cw(1, 4'b0111, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0025, 0, "r_or",  cw(1, 4'b0011, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0027, 0, "r_nor", cw(1, 4'b0101, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0026, 0, "r_xor", cw(1, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0000_0002, 0, "r_srl", cw(1, 4'b1000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
`ifdef CONTROLLER_MUL_EN
        step(32'h0000_0018, 0, "r_mul", cw(1, 4'b1001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
`else
        step(32'h0000_0018, 0, "r_mul_disabled", ZERO);
`endif
        step(32'h0000_0001, 0, "r_undef_funct", ZERO);

        // Branches
        step(32'h1000_0004, 0, "beq",  cw(0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h1400_0000, 0, "bne",  cw(0, 4'b1010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0400_0000, 0, "bltz", cw(0, 4'b1011, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0401_0000, 0, "bgez", cw(0, 4'b1100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h0402_0000, 0, "regimm_undef", ZERO);

        // Immediate ALU
        step(32'h2000_0000, 0, "addi", cw(0, 4'b0000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h3000_0000, 0, "andi", cw(0, 4'b0010, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h3400_0000, 0, "ori",  cw(0, 4'b0011, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h3800_0000, 0, "xori", cw(0, 4'b0100, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'h2800_0000, 0, "slti", cw(0, 4'b0110, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));

        // Memory
        step(32'h8C00_0000, 0, "lw", cw(0, 4'b0000, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00));
        step(32'h8400_0000, 0, "lh", cw(0, 4'b0000, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b01));
        step(32'h8000_0000, 0, "lb", cw(0, 4'b0000, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b10));
        step(32'hAC00_0000, 0, "sw", cw(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00));
        step(32'hA400_0000, 0, "sh", cw(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01));
        step(32'hA000_0000, 0, "sb", cw(0, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10));

        // Jumps
        step(32'h0800_0000, 0, "j",   cw(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        step(32'h0000_0008, 0, "jr",  cw(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00));
        step(32'h0C00_0000, 0, "jal", cw(0, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 0, 1, 2'b00));

        // Flush and undefined opcodes
        step(32'h2000_0000, 1, "flush_addi", ZERO);
        step(32'h2000_0000, 0, "addi_after_flush", cw(0, 4'b0000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        step(32'hFC00_0000, 0, "opcode_3f", ZERO);
        step(32'h8C00_0000, 0, "lw_again", cw(0, 4'b0000, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00));

        // Reset beats Flush and decode
        @(negedge Clk);
        Flush = 1'b1; Reset = 1'b1; #1;
        check("reset_over_flush", ZERO);
        @(negedge Clk);
        Flush = 1'b0; Reset = 1'b0;
        step(32'h0000_0020, 0, "add_final", cw(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
